// File: rtl/mmio_pkg.sv
// Shared constants and register decode for the MMIO timer peripheral.
// Offsets are byte offsets within the 256-byte peripheral window.
package mmio_pkg;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h4000_0000;

    localparam logic [7:0] OFF_TH      = 8'h00;
    localparam logic [7:0] OFF_TL      = 8'h04;
    localparam logic [7:0] OFF_TCON    = 8'h08;
    localparam logic [7:0] OFF_LEDS    = 8'h0C;
    localparam logic [7:0] OFF_BCD7    = 8'h10;
    localparam logic [7:0] OFF_SYSTICK = 8'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LEDS,
        SEL_BCD7,
        SEL_SYSTICK,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_off(input logic [7:0] byte_off);
        case (byte_off)
            OFF_TH:      return SEL_TH;
            OFF_TL:      return SEL_TL;
            OFF_TCON:    return SEL_TCON;
            OFF_LEDS:    return SEL_LEDS;
            OFF_BCD7:    return SEL_BCD7;
            OFF_SYSTICK: return SEL_SYSTICK;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timer_core.sv
// Prescaled reload timer: TH/TL/TCON registers and the registered interrupt request.
// CPU writes land at the edge ending the strobe cycle and take priority over timer updates.
module mmio_timer_core
    import mmio_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we_i,
    input  logic        tl_we_i,
    input  logic        tcon_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   th_q, th_d;
    logic [31:0]   tl_q, tl_d;
    logic [2:0]    tcon_q, tcon_d;
    logic          irq_q, irq_d;
    logic          tick, ovf, ovf_set;

    assign tick    = tcon_q[TCON_EN] && (cnt_q == PS_LAST);
    // A CPU store to TL in the tick cycle suppresses both increment and overflow.
    assign ovf     = tick && !tl_we_i && (tl_q == 32'hFFFF_FFFF);
    assign ovf_set = ovf && tcon_q[TCON_IE];

    always_comb begin
        cnt_d = cnt_q;
        if (!tcon_q[TCON_EN] || (tcon_we_i && !wdata_i[TCON_EN])) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        th_d = th_we_i ? wdata_i : th_q;

        tl_d = tl_q;
        if (tl_we_i) begin
            tl_d = wdata_i;
        end else if (ovf) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        // Overflow ORs into the status bit so a same-cycle TCON store cannot drop it.
        tcon_d          = tcon_we_i ? wdata_i[2:0] : tcon_q;
        tcon_d[TCON_IS] = tcon_d[TCON_IS] | ovf_set;

        irq_d = tcon_d[TCON_IE] & tcon_d[TCON_IS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            irq_q  <= irq_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/mmio_timer_periph.sv
// MEM-stage peripheral responder: window decode, LEDs/BCD7/SysTick registers, read mux.
// Zero-wait-state reads from registered state; stores commit at the end of the strobe cycle.
module mmio_timer_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [31:0] LEDs,
    output logic [31:0] BCD7,
    output logic [31:0] SysTick,
    output logic        Irq
);

    logic        in_win;
    logic        we;
    reg_sel_e    sel;
    logic        addr_unused;

    logic [31:0] leds_q, leds_d;
    logic [11:0] bcd_q, bcd_d;
    logic [31:0] systick_q;

    logic [31:0] th, tl;
    logic [2:0]  tcon;

    assign in_win      = (addr[31:8] == ADDR_BASE[31:8]);
    assign sel         = decode_off({addr[7:2], 2'b00});
    assign addr_unused = ^addr[1:0];
    assign hit         = in_win & (mem_read | mem_write);
    assign we          = in_win & mem_write;

    mmio_timer_core #(
        .PRESCALE (PRESCALE)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .th_we_i   (we && (sel == SEL_TH)),
        .tl_we_i   (we && (sel == SEL_TL)),
        .tcon_we_i (we && (sel == SEL_TCON)),
        .wdata_i   (wdata),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (Irq)
    );

    always_comb begin
        leds_d = leds_q;
        bcd_d  = bcd_q;
        if (we && (sel == SEL_LEDS)) begin
            leds_d = wdata;
        end
        if (we && (sel == SEL_BCD7)) begin
            bcd_d = wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q    <= '0;
            bcd_q     <= '0;
            systick_q <= '0;
        end else begin
            leds_q    <= leds_d;
            bcd_q     <= bcd_d;
            systick_q <= systick_q + 32'd1;
        end
    end

    // Read data reflects pre-write state, so a combined read+write returns the old value.
    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (sel)
                SEL_TH:      rdata = th;
                SEL_TL:      rdata = tl;
                SEL_TCON:    rdata = {29'd0, tcon};
                SEL_LEDS:    rdata = leds_q;
                SEL_BCD7:    rdata = {20'd0, bcd_q};
                SEL_SYSTICK: rdata = systick_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign LEDs    = leds_q;
    assign BCD7    = {20'd0, bcd_q};
    assign SysTick = systick_q;

endmodule
